// File: rtl/acc_mag_inv_sqrt.sv
// Iterative fixed-point inverse square root for the accelerometer normaliser.
// Digit-by-digit root, then restoring division, one operation in flight.
module acc_mag_inv_sqrt #(
  parameter int IN_WIDTH  = 24,
  parameter int SQ_FRAC   = 8,
  parameter int OUT_FRAC  = 20,
  parameter int OUT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [OUT_WIDTH-1:0] data_out
);

  localparam int RW  = IN_WIDTH + 2 * SQ_FRAC;
  localparam int SN  = RW / 2;
  localparam int DN  = OUT_FRAC + SQ_FRAC + 1;
  localparam int RMW = SN + 1;
  localparam int CW  = $clog2(SN + DN + 1);

  localparam logic [CW-1:0] SQ_LAST = CW'(SN - 1);
  localparam logic [CW-1:0] DV_LAST = CW'(DN);

  typedef enum logic [1:0] {
    IDLE,
    SQRT,
    DIV,
    DONE
  } state_t;

  state_t               state;
  logic [RW-1:0]        rad;
  logic [RMW-1:0]       rem;
  logic [SN-1:0]        root;
  logic [SN-1:0]        pr;
  logic [OUT_WIDTH-1:0] q;
  logic [CW-1:0]        cnt;

  logic [SN+2:0]        rem_sh;
  logic [SN+2:0]        trial;
  logic [SN+2:0]        rem_nx;
  logic                 sq_ge;
  logic [SN:0]          pr_sh;
  logic [SN:0]          dvs;
  logic [SN:0]          pr_nx;
  logic                 dv_ge;

  // One root digit and one quotient bit per cycle; the
  // partial remainders carry a guard bit above the operand.
  always_comb begin
    rem_sh = {rem, rad[RW-1 -: 2]};
    trial  = {1'b0, root, 2'b01};
    sq_ge  = rem_sh >= trial;
    rem_nx = sq_ge ? rem_sh - trial : rem_sh;
    pr_sh  = {pr, cnt == '0};
    dvs    = {1'b0, root};
    dv_ge  = pr_sh >= dvs;
    pr_nx  = dv_ge ? pr_sh - dvs : pr_sh;
  end

  // Control FSM plus datapath registers; the dividend is
  // 2^(DN-1), so its only set bit enters on the first step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      data_out  <= '0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      pr        <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_in && ready_in) begin
            rad      <= RW'(data_in) << (2 * SQ_FRAC);
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            ready_in <= 1'b0;
            state    <= SQRT;
          end
        end
        SQRT: begin
          rad  <= rad << 2;
          rem  <= RMW'(rem_nx);
          root <= {root[SN-2:0], sq_ge};
          if (cnt == SQ_LAST) begin
            cnt   <= '0;
            pr    <= '0;
            q     <= '0;
            state <= DIV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == DV_LAST) begin
            data_out  <= (root == '0) ? '1 : q;
            valid_out <= 1'b1;
            state     <= DONE;
          end else begin
            pr  <= SN'(pr_nx);
            q   <= OUT_WIDTH'({q, dv_ge});
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_mag_inv_sqrt.sv
// Directed-vector and random bench for acc_mag_inv_sqrt.
// Expected values come from hand-computed tables and a search model.
module tb_acc_mag_inv_sqrt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out = 1'b0;
  logic [23:0] data_in = '0;
  logic        ready_in;
  logic        valid_out;
  logic [23:0] data_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [23:0] x;
    logic [23:0] q;
    string       nm;
  } vec_t;

  vec_t vecs[7];

  acc_mag_inv_sqrt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Root by binary search on s*s <= x*2^16, then plain division.
  function automatic logic [23:0] ref_q(input logic [23:0] x);
    longint unsigned r, lo, hi, mid;
    if (x == 24'd0) return 24'hFFFFFF;
    r  = {40'd0, x} << 16;
    lo = 0;
    hi = 64'd1 << 21;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    return 24'((64'd1 << 28) / lo);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [23:0] x,
                       input logic [23:0] exp,
                       input int vdly,
                       input int rdly,
                       input string nm);
    int n;
    logic [23:0] hold;
    logic ok;
    repeat (vdly) step();
    valid_in = 1'b1;
    data_in  = x;
    n = 0;
    while (!ready_in && n < 100) begin
      step();
      n++;
    end
    if (!ready_in) begin
      check({nm, " accept"}, 32'(ready_in), 32'd1);
      valid_in = 1'b0;
      return;
    end
    step();
    valid_in = 1'b0;
    data_in  = 24'($urandom);
    n = 0;
    while (!valid_out && n < 200) begin
      step();
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'd50);
    if (!valid_out) return;
    check({nm, " data"}, 32'(data_out), 32'(exp));
    hold = data_out;
    ok = 1'b1;
    repeat (rdly) begin
      valid_in = 1'($urandom);
      data_in  = 24'($urandom);
      step();
      if (data_out !== hold || valid_out !== 1'b1 ||
          ready_in !== 1'b0)
        ok = 1'b0;
    end
    valid_in = 1'b0;
    if (rdly > 0) check({nm, " stall"}, 32'(ok), 32'd1);
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
    check({nm, " vout_clr"}, 32'(valid_out), 32'd0);
    check({nm, " rdy_back"}, 32'(ready_in), 32'd1);
  endtask

  task automatic rst_mid(input logic [23:0] x,
                         input int wait_edges,
                         input string nm);
    logic ok;
    valid_in = 1'b1;
    data_in  = x;
    step();
    valid_in = 1'b0;
    repeat (wait_edges) step();
    rst_n = 1'b0;
    #1;
    check({nm, " rdy"}, 32'(ready_in), 32'd1);
    check({nm, " vout"}, 32'(valid_out), 32'd0);
    check({nm, " dout"}, 32'(data_out), 32'd0);
    step();
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (80) begin
      step();
      if (valid_out !== 1'b0 || ready_in !== 1'b1) ok = 1'b0;
    end
    check({nm, " quiet"}, 32'(ok), 32'd1);
  endtask

  initial begin
    logic ok;
    logic [23:0] x;

    vecs[0] = '{24'd1,        24'h100000, "x1"};
    vecs[1] = '{24'd4,        24'h080000, "x4"};
    vecs[2] = '{24'd16,       24'h040000, "x16"};
    vecs[3] = '{24'd152500,   24'h000A7D, "norm"};
    vecs[4] = '{24'd0,        24'hFFFFFF, "zero"};
    vecs[5] = '{24'hFFFFFF,   24'h000100, "max"};
    vecs[6] = '{24'd2,        24'h0B509E, "x2"};

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst ready_in", 32'(ready_in), 32'd1);
    check("rst valid_out", 32'(valid_out), 32'd0);
    check("rst data_out", 32'(data_out), 32'd0);

    ok = 1'b1;
    repeat (100) begin
      data_in = 24'($urandom);
      step();
      if (ready_in !== 1'b1 || valid_out !== 1'b0 ||
          data_out !== 24'd0)
        ok = 1'b0;
    end
    check("idle hold", 32'(ok), 32'd1);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].x, vecs[i].q, 0, 0, vecs[i].nm);

    do_op(24'd9, 24'h055555, 0, 30, "bp");

    rst_mid(24'd16, 10, "rst_sqrt");
    do_op(24'd4, 24'h080000, 0, 0, "pre_div");
    rst_mid(24'd16, 35, "rst_div");
    do_op(24'd1, 24'h100000, 0, 0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      x = 24'($urandom) >> $urandom_range(0, 24);
      do_op(x, ref_q(x), $urandom_range(0, 3),
            $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
